// File: rtl/cnt_arb_ctrl_pkg.sv
// cnt_arb_ctrl_pkg
// Shared types and constants for the two-requester counter arbitration
// controller: default counter width, requester count and FSM state type.
package cnt_arb_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int NUM_REQ   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way arbiter. Default build: round-robin with a one-bit pointer that
// favours requester 0 after reset. With CNT_ARB_CTRL_FIXED_PRIO_EN defined it
// is a fixed-priority encoder (requester 0 wins) and the pointer is removed.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   req      in   [NUM_REQ] pending requests
//   advance  in   pulse: job of 'last' finished or aborted, move the pointer
//   last     in   [NUM_REQ] one-hot owner of the job that just ended
//   winner   out  [NUM_REQ] one-hot winner (combinational), 0 if no request
module rr_arb2
  import cnt_arb_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] winner
);

`ifdef CNT_ARB_CTRL_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clock, reset, advance, last};

  always_comb begin
    winner    = '0;
    winner[0] = req[0];
    winner[1] = req[1] & ~req[0];
  end

`else

  // ptr_reg = 0 favours requester 0, 1 favours requester 1.
  logic ptr_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg <= 1'b0;
    end else if (advance) begin
      // Favour whichever requester did not own the job that just ended.
      ptr_reg <= last[0];
    end
  end

  always_comb begin
    winner = req;                       // single request is already one-hot
    if (req == 2'b11) begin
      winner = ptr_reg ? 2'b10 : 2'b01;
    end
  end

`endif

endmodule

// File: rtl/cnt_arb_ctrl.sv
// cnt_arb_ctrl
// Shares one loadable up-counter between two requesters. A granted requester
// gets the counter loaded with its start value and enabled until the counter
// reaches its limit (wrapping modulo 2^WIDTH), then receives a one-cycle done.
// Optional macro CNT_ARB_CTRL_FIXED_PRIO_EN selects fixed priority (requester
// 0 wins simultaneous requests) instead of round-robin.
//
// Ports:
//   clock, reset       clock and synchronous active-high reset
//   req[1:0]           per-requester run request, held until done or abort
//   start0/limit0      requester 0 start / terminal value, sampled at grant
//   start1/limit1      requester 1 start / terminal value, sampled at grant
//   grant[1:0]         one-hot owner, 0 when idle
//   done[1:0]          one-cycle completion pulse to the owner
//   busy               high whenever not idle
//   cnt_enable         counter enable
//   cnt_load           counter load
//   cnt_load_val       counter load value
//   cnt_value          counter current value
module cnt_arb_ctrl
  import cnt_arb_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   start0,
  input  logic [WIDTH-1:0]   limit0,
  input  logic [WIDTH-1:0]   start1,
  input  logic [WIDTH-1:0]   limit1,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               cnt_enable,
  output logic               cnt_load,
  output logic [WIDTH-1:0]   cnt_load_val,
  input  logic [WIDTH-1:0]   cnt_value
);

  state_t               state_reg;
  state_t               state_next;
  logic [NUM_REQ-1:0]   owner_reg;
  logic [WIDTH-1:0]     start_reg;
  logic [WIDTH-1:0]     limit_reg;
  logic                 hit_reg;
  logic [NUM_REQ-1:0]   winner;
  logic                 active;
  logic                 abort;
  logic                 at_limit;
  logic                 advance;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .last    (owner_reg),
    .winner  (winner)
  );

  assign active   = (state_reg == ST_LOAD) || (state_reg == ST_RUN);
  // Owner withdrew its request while the counter is in use.
  assign abort    = active && ((req & owner_reg) == '0);
  assign at_limit = (cnt_value == limit_reg);
  assign advance  = (state_reg == ST_DONE) || abort;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req != '0) state_next = ST_LOAD;
      ST_LOAD: state_next = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort)        state_next = ST_IDLE;
        else if (hit_reg) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      owner_reg <= '0;
      start_reg <= '0;
      limit_reg <= '0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_IDLE) && (req != '0)) begin
        owner_reg <= winner;
        start_reg <= winner[1] ? start1 : start0;
        limit_reg <= winner[1] ? limit1 : limit0;
      end
      // The terminal compare is registered: the counter sits on the limit
      // with enable low for one cycle before the FSM moves to DONE.
      hit_reg <= (state_reg == ST_RUN) && !abort && at_limit;
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign cnt_load     = (state_reg == ST_LOAD) && !abort;
  assign cnt_enable   = cnt_load ||
                        ((state_reg == ST_RUN) && !abort && !at_limit);
  assign cnt_load_val = cnt_load ? start_reg : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign grant[gi] = busy && owner_reg[gi];
      assign done[gi]  = (state_reg == ST_DONE) && owner_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_cnt_arb_ctrl.sv
// tb_cnt_arb_ctrl
// Directed bench for cnt_arb_ctrl with a behavioural up-counter attached to
// the controller's counter interface. Job vectors are table-driven; reset,
// contention, abort and reset-mid-run are hand-written sequences.
module tb_cnt_arb_ctrl;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic [1:0]   req;
  logic [W-1:0] start0, limit0, start1, limit1;
  logic [1:0]   grant, done;
  logic         busy, cnt_enable, cnt_load;
  logic [W-1:0] cnt_load_val;
  logic [W-1:0] cnt = '0;

  int checks = 0;
  int errors = 0;

  cnt_arb_ctrl #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .start0       (start0),
    .limit0       (limit0),
    .start1       (start1),
    .limit1       (limit1),
    .grant        (grant),
    .done         (done),
    .busy         (busy),
    .cnt_enable   (cnt_enable),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_value    (cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Loadable up-counter: load wins over enable, wraps modulo 2^W.
  always_ff @(posedge clock) begin
    if (cnt_load)        cnt <= cnt_load_val;
    else if (cnt_enable) cnt <= cnt + 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [1:0] rq;      // single requester; also the expected grant/done
    logic [3:0] st;
    logic [3:0] lim;
    int         d;       // (lim - st) mod 16, hand computed
  } vec_t;

  vec_t vecs[6];

  // One job with a single requester. Called one time unit after an edge with
  // the DUT idle. Edge N samples req; done must be seen after edge N+3+d.
  task automatic run_job(input vec_t v);
    int k;
    int incs;
    bit seen;
    req = v.rq;
    if (v.rq == 2'b01) begin
      start0 = v.st; limit0 = v.lim; start1 = ~v.st; limit1 = ~v.lim;
    end else begin
      start1 = v.st; limit1 = v.lim; start0 = ~v.st; limit0 = ~v.lim;
    end
    tick();                                   // edge N
    check({v.name, "_grant"}, grant, v.rq);
    check({v.name, "_load"}, cnt_load, 1);
    check({v.name, "_load_val"}, cnt_load_val, v.st);
    // Inputs must be ignored once latched.
    start0 = start0 + 4'd3; limit0 = limit0 + 4'd5;
    start1 = start1 + 4'd3; limit1 = limit1 + 4'd5;
    incs = 0;
    seen = 0;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();                                 // edge N+i
      if (done != 2'b00) begin
        k = i;
        seen = 1;
        break;
      end
      if (cnt_enable && !cnt_load) incs++;
    end
    if (!seen) begin
      check({v.name, "_done_timeout"}, 0, 1);
    end else begin
      check({v.name, "_latency"}, k, 3 + v.d);
      check({v.name, "_done"}, done, v.rq);
      check({v.name, "_grant_held"}, grant, v.rq);
      check({v.name, "_incs"}, incs, v.d);
      check({v.name, "_cnt_final"}, cnt, v.lim);
      check({v.name, "_en_at_done"}, cnt_enable, 0);
    end
    req = 2'b00;
    tick();
    check({v.name, "_done_pulse"}, done, 0);
    check({v.name, "_idle"}, busy, 0);
    check({v.name, "_cnt_hold"}, cnt, v.lim);
    $display("job %s req=%b start=%0d limit=%0d latency=%0d incs=%0d",
             v.name, v.rq, v.st, v.lim, k, incs);
  endtask

  logic [1:0] seq[3];
  logic [1:0] exp_seq[3];
  logic [1:0] prev_done;
  int         n;

  initial begin
    vecs[0] = '{"single0", 2'b01, 4'd2,  4'd5,  3};
    vecs[1] = '{"wrap1",   2'b10, 4'd14, 4'd1,  3};
    vecs[2] = '{"zero0",   2'b01, 4'd7,  4'd7,  0};
    vecs[3] = '{"full1",   2'b10, 4'd0,  4'd15, 15};
    vecs[4] = '{"zero1",   2'b10, 4'd9,  4'd9,  0};
    vecs[5] = '{"wrap0",   2'b01, 4'd15, 4'd0,  1};

    // ---- reset with both requests pending ----
    reset = 1'b1; req = 2'b11;
    start0 = 4'd1; limit0 = 4'd2; start1 = 4'd5; limit1 = 4'd5;
    tick(); tick();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_en", cnt_enable, 0);
    check("rst_load", cnt_load, 0);
    check("rst_load_val", cnt_load_val, 0);
    $display("reset grant=%b busy=%b", grant, busy);

    // ---- contention from reset: req=11 held ----
    reset = 1'b0;
    n = 0;
    prev_done = 2'b00;
`ifdef CNT_ARB_CTRL_FIXED_PRIO_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
`endif
    for (int i = 0; i < 200 && n < 3; i++) begin
      tick();
      if (prev_done != 2'b00) check("cont_idle_gap", busy, 0);
      if (done != 2'b00) begin
        seq[n] = done;
        n++;
      end
      prev_done = done;
    end
    check("cont_jobs", n, 3);
    for (int j = 0; j < 3; j++) begin
      if (j < n) begin
        check($sformatf("cont_order%0d", j), seq[j], exp_seq[j]);
        $display("contention job %0d done=%b", j, seq[j]);
      end
    end
    req = 2'b00;
    tick(); tick();

    // ---- table-driven single jobs ----
    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i]);
    end

    // ---- abort: start0=0 limit0=9, req0 dropped at cnt=4 ----
    req = 2'b01; start0 = 4'd0; limit0 = 4'd9;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done != 2'b00) n++;
      if (cnt == 4'd4 && busy) break;
    end
    check("abort_reach4", cnt, 4);
    check("abort_en_before", cnt_enable, 1);
    req = 2'b00;
    #1;
    check("abort_en_same_cycle", cnt_enable, 0);
    tick();
    if (done != 2'b00) n++;
    check("abort_idle", busy, 0);
    check("abort_cnt_hold", cnt, 4);
    check("abort_no_done", n, 0);
    req = 2'b11;
    tick();
`ifdef CNT_ARB_CTRL_FIXED_PRIO_EN
    check("abort_ptr", grant, 2'b01);
`else
    check("abort_ptr", grant, 2'b10);
`endif
    $display("abort cnt=%0d next_grant=%b", cnt, grant);
    req = 2'b00;                              // aborts the new job
    tick();
    check("abort2_idle", busy, 0);

    // ---- reset mid-run at cnt=3 ----
    req = 2'b01; start0 = 4'd0; limit0 = 4'd9;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cnt == 4'd3 && busy) break;
    end
    check("rmr_reach3", cnt, 3);
    reset = 1'b1;
    tick();
    check("rmr_grant", grant, 0);
    check("rmr_done", done, 0);
    check("rmr_busy", busy, 0);
    check("rmr_en", cnt_enable, 0);
    check("rmr_load", cnt_load, 0);
    check("rmr_load_val", cnt_load_val, 0);
    reset = 1'b0;
    req = 2'b00;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done != 2'b00) n++;
    end
    check("rmr_no_done", n, 0);
    $display("reset mid-run busy=%b grant=%b", busy, grant);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
